// File: rtl/lif_array_pkg.sv
// Shared types and helpers for the LIF neuron array: FSM state encoding,
// reset-mode constants and a width-generic saturating adder.
package lif_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } lif_state_e;

    localparam logic RESET_HARD = 1'b0;
    localparam logic RESET_SOFT = 1'b1;

    // Unsigned add clamped to 2^q-1; callers cast the result back to q bits.
    function automatic logic [31:0] sat_add(input logic [31:0] a, input logic [31:0] b, input int q);
        logic [32:0] sum;
        logic [32:0] lim;
        sum = {1'b0, a} + {1'b0, b};
        lim = (33'd1 << q) - 33'd1;
        return (sum > lim) ? lim[31:0] : sum[31:0];
    endfunction

endpackage

// File: rtl/lif_array_if.sv
// Input-timestep and output-spike handshakes of the LIF array.
// A transfer happens on a rising edge where valid and ready are both high; valid holds its payload until then.
interface lif_array_if #(
    parameter int N = 8,
    parameter int Q = 10,
    parameter int T = 16
);
    logic                 in_valid;
    logic                 in_ready;
    logic [N*Q-1:0]       in_data;
    logic                 out_valid;
    logic                 out_ready;
    logic [N-1:0]         out_spikes;
    logic [$clog2(T)-1:0] out_step;

    modport master (
        output in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_spikes, out_step
    );

    modport slave (
        input  in_valid, in_data, out_ready,
        output in_ready, out_valid, out_spikes, out_step
    );
endinterface

// File: rtl/lif_neuron_core.sv
// One LIF channel: membrane potential and refractory counter, with leak,
// saturating integration and threshold firing evaluated combinationally per step.
module lif_neuron_core
    import lif_pkg::*;
#(
    parameter int Q     = 10,
    parameter int REF_W = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     i_clear,
    input  logic                     i_step,
    input  logic [Q-1:0]             i_in,
    input  logic [Q-1:0]             i_threshold,
    input  logic [$clog2(Q+1)-1:0]   i_leak_shift,
    input  logic                     i_reset_mode,
    input  logic [REF_W-1:0]         i_ref_cycles,
    output logic                     o_spike
);
    logic [Q-1:0]     r_v;
    logic [REF_W-1:0] r_ref;
    logic [Q-1:0]     w_leak;
    logic [Q-1:0]     w_vl;
    logic [Q-1:0]     w_sum;
    logic             w_refr;

    always_comb begin
        w_leak = '0;
        if (i_leak_shift != '0 && 32'(i_leak_shift) <= Q)
            w_leak = r_v >> i_leak_shift;
        w_vl    = r_v - w_leak;
        w_sum   = Q'(sat_add(32'(w_vl), 32'(i_in), Q));
        w_refr  = (r_ref != '0);
        o_spike = !w_refr && (w_sum > i_threshold);
    end

    always_ff @(posedge clk) begin
        if (rst || i_clear) begin
            r_v   <= '0;
            r_ref <= '0;
        end else if (i_step) begin
            if (w_refr) begin
                // Refractory steps discard the input and pin the potential at zero.
                r_v   <= '0;
                r_ref <= r_ref - 1'b1;
            end else if (o_spike) begin
                r_v   <= (i_reset_mode == RESET_SOFT) ? (w_sum - i_threshold) : '0;
                r_ref <= i_ref_cycles;
            end else begin
                r_v   <= w_sum;
            end
        end
    end
endmodule

// File: rtl/lif_array.sv
// N-channel LIF array over T timesteps: run FSM, step counter, registered
// spike output stage and the full spike raster.
module lif_array
    import lif_pkg::*;
#(
    parameter int N     = 8,
    parameter int T     = 16,
    parameter int Q     = 10,
    parameter int REF_W = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     start,
    input  logic [Q-1:0]             threshold,
    input  logic [$clog2(Q+1)-1:0]   leak_shift,
    input  logic                     reset_mode,
    input  logic [REF_W-1:0]         ref_cycles,
    lif_array_if.slave               bus,
    output logic [N*T-1:0]           spike_raster,
    output logic                     busy,
    output logic                     lif_done,
    output lif_state_e               o_dbg_state
);
    localparam int STEP_W = $clog2(T);

    lif_state_e                r_state;
    lif_state_e                w_next;
    logic [STEP_W-1:0]         r_step;
    logic                      r_out_valid;
    logic [N-1:0]              r_out_spikes;
    logic [STEP_W-1:0]         r_out_step;
    logic [N-1:0][T-1:0]       r_raster;
    logic [Q-1:0]              r_threshold;
    logic [$clog2(Q+1)-1:0]    r_leak_shift;
    logic                      r_reset_mode;
    logic [REF_W-1:0]          r_ref_cycles;
    logic                      w_start;
    logic                      w_in_ready;
    logic                      w_in_fire;
    logic                      w_last_step;
    logic [N-1:0]              w_spike;

    assign w_start     = (r_state == IDLE) && start;
    assign w_in_ready  = (r_state == RUN) && (!r_out_valid || bus.out_ready);
    assign w_in_fire   = bus.in_valid && w_in_ready;
    assign w_last_step = (r_step == STEP_W'(T - 1));

    always_ff @(posedge clk) begin
        if (rst) r_state <= IDLE;
        else     r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    if (start) w_next = RUN;
            RUN:     if (w_in_fire && w_last_step) w_next = DRAIN;
            // Leave DRAIN once the output register is empty or empties this edge.
            DRAIN:   if (!r_out_valid || bus.out_ready) w_next = DONE;
            DONE:    w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_threshold  <= '0;
            r_leak_shift <= '0;
            r_reset_mode <= RESET_HARD;
            r_ref_cycles <= '0;
        end else if (w_start) begin
            r_threshold  <= threshold;
            r_leak_shift <= leak_shift;
            r_reset_mode <= reset_mode;
            r_ref_cycles <= ref_cycles;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_step       <= '0;
            r_raster     <= '0;
            r_out_valid  <= 1'b0;
            r_out_spikes <= '0;
            r_out_step   <= '0;
        end else begin
            if (w_start) begin
                r_step   <= '0;
                r_raster <= '0;
            end else if (w_in_fire) begin
                r_step <= r_step + 1'b1;
                for (int c = 0; c < N; c++)
                    r_raster[c][r_step] <= w_spike[c];
            end
            if (w_in_fire) begin
                r_out_valid  <= 1'b1;
                r_out_spikes <= w_spike;
                r_out_step   <= r_step;
            end else if (r_out_valid && bus.out_ready) begin
                r_out_valid <= 1'b0;
            end
        end
    end

    for (genvar c = 0; c < N; c++) begin : g_ch
        lif_neuron_core #(.Q(Q), .REF_W(REF_W)) u_core (
            .clk          (clk),
            .rst          (rst),
            .i_clear      (w_start),
            .i_step       (w_in_fire),
            .i_in         (bus.in_data[c*Q +: Q]),
            .i_threshold  (r_threshold),
            .i_leak_shift (r_leak_shift),
            .i_reset_mode (r_reset_mode),
            .i_ref_cycles (r_ref_cycles),
            .o_spike      (w_spike[c])
        );
    end

    assign bus.in_ready   = w_in_ready;
    assign bus.out_valid  = r_out_valid;
    assign bus.out_spikes = r_out_spikes;
    assign bus.out_step   = r_out_step;
    assign spike_raster   = r_raster;
    assign busy           = (r_state == RUN) || (r_state == DRAIN);
    assign lif_done       = (r_state == DONE);
    assign o_dbg_state    = r_state;
endmodule
